// File: rtl/alu_md_unit.sv
// rtl/alu_md_unit.sv - single-cycle ALU plus iterative multiply/divide execution unit
// ALU ops pulse the cycle after issue; MD ops take a fixed XLEN+1 edges regardless of data.
module alu_md_unit #(
  parameter int XLEN      = 32,
  parameter int RS_WIDTH  = 2,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      a,
  input  logic [XLEN-1:0]      b,
  input  logic [3:0]           alu_op,
  input  logic                 is_md,
  input  logic [2:0]           md_op,
  input  logic [RS_WIDTH-1:0]  in_rs_index,
  input  logic [ROB_WIDTH-1:0] in_rob_tag,
  output logic                 out_valid,
  output logic [RS_WIDTH-1:0]  out_rs_index,
  output logic [ROB_WIDTH-1:0] out_rob_tag,
  output logic [XLEN-1:0]      out_result,
  output logic                 busy
);
  localparam int SW = $clog2(XLEN);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;

  logic [1:0]           state;
  logic [SW-1:0]        counter;
  logic [2:0]           op_q;
  logic                 neg_q, neg_r, b_zero;
  logic [XLEN-1:0]      hi, lo, m;
  logic [RS_WIDTH-1:0]  rs_q;
  logic [ROB_WIDTH-1:0] rob_q;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  assign shamt = b[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0:  alu_res = a + b;
      4'd1:  alu_res = a - b;
      4'd2:  alu_res = a & b;
      4'd3:  alu_res = a | b;
      4'd4:  alu_res = a ^ b;
      4'd5:  alu_res = a << shamt;
      4'd6:  alu_res = a >> shamt;
      4'd7:  alu_res = $signed(a) >>> shamt;
      4'd8:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'd9:  alu_res = {{(XLEN-1){1'b0}}, a < b};
      4'd10: alu_res = {{(XLEN-1){1'b0}}, a == b};
      4'd11: alu_res = {{(XLEN-1){1'b0}}, $signed(a) >= $signed(b)};
      4'd12: alu_res = {{(XLEN-1){1'b0}}, a >= b};
      4'd13: alu_res = {{(XLEN-1){1'b0}}, a != b};
      4'd14: alu_res = a + b - XLEN'(4);
      default: alu_res = '0;
    endcase
  end

  // Operands are reduced to magnitudes so the iterative core is purely unsigned.
  logic            sa, sb;
  logic [XLEN-1:0] abs_a, abs_b;
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (md_op)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
        sa = a[XLEN-1];
        sb = b[XLEN-1];
      end
      MD_MULHSU: sa = a[XLEN-1];
      default: ;
    endcase
  end
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;

  logic [XLEN:0]   sum, shifted;
  logic            ge;
  logic [XLEN-1:0] diff;
  assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
  assign shifted = {hi, lo[XLEN-1]};
  assign ge      = shifted >= {1'b0, m};
  assign diff    = shifted[XLEN-1:0] - m;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, md_res;
  assign prod = neg_q ? -{hi, lo} : {hi, lo};
  assign quo  = b_zero ? '1 : (neg_q ? -lo : lo);
  assign rem  = neg_r ? -hi : hi;

  always_comb begin
    case (op_q)
      MD_MUL:                       md_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: md_res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              md_res = quo;
      default:                      md_res = rem;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= ST_IDLE;
      counter      <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      b_zero       <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      m            <= '0;
      rs_q         <= '0;
      rob_q        <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_rs_index <= '0;
      out_rob_tag  <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        state     <= ST_IDLE;
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        case (state)
          ST_IDLE: if (in_valid) begin
            if (is_md) begin
              op_q    <= md_op;
              neg_q   <= sa ^ sb;
              neg_r   <= sa;
              b_zero  <= (b == '0);
              hi      <= '0;
              lo      <= md_op[2] ? abs_a : abs_b;
              m       <= md_op[2] ? abs_b : abs_a;
              rs_q    <= in_rs_index;
              rob_q   <= in_rob_tag;
              counter <= '0;
              state   <= ST_RUN;
            end else begin
              out_result   <= alu_res;
              out_rs_index <= in_rs_index;
              out_rob_tag  <= in_rob_tag;
              out_valid    <= 1'b1;
            end
          end
          ST_RUN: begin
            if (op_q[2]) begin
              hi <= ge ? diff : shifted[XLEN-1:0];
              lo <= {lo[XLEN-2:0], ge};
            end else begin
              hi <= sum[XLEN:1];
              lo <= {sum[0], lo[XLEN-1:1]};
            end
            counter <= counter + 1'b1;
            if (counter == SW'(XLEN-1)) state <= ST_FIX;
          end
          ST_FIX: begin
            out_result   <= md_res;
            out_rs_index <= rs_q;
            out_rob_tag  <= rob_q;
            out_valid    <= 1'b1;
            state        <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_md_unit.sv
// tb/tb_alu_md_unit.sv - randomized self-checking bench for alu_md_unit
// Expected results come from plain 32/64-bit arithmetic on the operands.
module tb_alu_md_unit;
  localparam int XLEN = 32;
  localparam int RSW  = 2;
  localparam int ROBW = 4;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b0;
  logic            rdy_in = 1'b1;
  logic            clear = 1'b0;
  logic            in_valid = 1'b0;
  logic            is_md = 1'b0;
  logic [XLEN-1:0] a = '0, b = '0;
  logic [3:0]      alu_op = '0;
  logic [2:0]      md_op = '0;
  logic [RSW-1:0]  in_rs_index = '0;
  logic [ROBW-1:0] in_rob_tag = '0;
  logic            in_ready, out_valid, busy;
  logic [RSW-1:0]  out_rs_index;
  logic [ROBW-1:0] out_rob_tag;
  logic [XLEN-1:0] out_result;

  int checks = 0;
  int errors = 0;

  alu_md_unit #(.XLEN(XLEN), .RS_WIDTH(RSW), .ROB_WIDTH(ROBW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .alu_op(alu_op),
    .is_md(is_md), .md_op(md_op), .in_rs_index(in_rs_index), .in_rob_tag(in_rob_tag),
    .out_valid(out_valid), .out_rs_index(out_rs_index), .out_rob_tag(out_rob_tag),
    .out_result(out_result), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    case (op)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return x << y[4:0];
      4'd6:  return x >> y[4:0];
      4'd7:  return sx >>> y[4:0];
      4'd8:  return (sx < sy) ? 32'd1 : 32'd0;
      4'd9:  return (x < y) ? 32'd1 : 32'd0;
      4'd10: return (x == y) ? 32'd1 : 32'd0;
      4'd11: return (sx >= sy) ? 32'd1 : 32'd0;
      4'd12: return (x >= y) ? 32'd1 : 32'd0;
      4'd13: return (x != y) ? 32'd1 : 32'd0;
      4'd14: return x + y - 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    p = 0;
    case (op)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        p = sx / sy;
        return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        p = sx % sy;
        return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic put_op(input logic md, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    in_valid    = 1'b1;
    is_md       = md;
    alu_op      = op;
    md_op       = op[2:0];
    a           = x;
    b           = y;
    in_rs_index = RSW'($urandom);
    in_rob_tag  = ROBW'($urandom);
  endtask

  task automatic alu_test(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input string name);
    logic [RSW+ROBW-1:0] tags;
    put_op(1'b0, op, x, y);
    tags = {in_rs_index, in_rob_tag};
    @(posedge clk_in); #1;
    in_valid = 1'b0;
    check_eq({name, "_v"}, out_valid, 1);
    check_eq(name, out_result, alu_ref(op, x, y));
    check_eq({name, "_tag"}, {out_rs_index, out_rob_tag}, tags);
  endtask

  task automatic md_test(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input string name, input bit stall);
    logic [RSW+ROBW-1:0] tags;
    int n, ready_bad;
    put_op(1'b1, {1'b0, op}, x, y);
    tags = {in_rs_index, in_rob_tag};
    @(posedge clk_in); #1;
    in_valid = 1'b0;
    n = 0;
    ready_bad = 0;
    while (!out_valid && n < 200) begin
      if (in_ready || !busy) ready_bad++;
      if (stall && n == 10) rdy_in = 1'b0;
      if (stall && n == 15) rdy_in = 1'b1;
      @(posedge clk_in); #1;
      n++;
    end
    rdy_in = 1'b1;
    check_eq({name, "_lat"}, n, stall ? 38 : 33);
    check_eq({name, "_rdylow"}, ready_bad, 0);
    check_eq(name, out_result, md_ref(op, x, y));
    check_eq({name, "_tag"}, {out_rs_index, out_rob_tag}, tags);
    check_eq({name, "_rdy"}, in_ready, 1);
  endtask

  initial begin
    int pulses;
    #12;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_result", out_result, 0);
    check_eq("rst_tags", {out_rs_index, out_rob_tag}, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    alu_test(4'd0, 32'd5, 32'd7, "add");
    alu_test(4'd1, 32'd0, 32'd1, "sub");
    alu_test(4'd7, 32'h8000_0000, 32'd4, "sra");
    alu_test(4'd14, 32'h100, 32'd8, "addpc");
    alu_test(4'd8, 32'hFFFF_FFFF, 32'd1, "slt");
    alu_test(4'd9, 32'hFFFF_FFFF, 32'd1, "sltu");
    alu_test(4'd11, 32'hFFFF_FFFF, 32'd1, "bge");
    alu_test(4'd12, 32'hFFFF_FFFF, 32'd1, "bgeu");
    alu_test(4'd15, 32'd3, 32'd9, "rsvd");
    @(posedge clk_in); #1;
    check_eq("pulse_end", out_valid, 0);

    for (int i = 0; i < 150; i++) begin
      alu_test(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd(), "alu_rnd");
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_in); #1;
        check_eq("alu_idle", out_valid, 0);
      end
    end

    md_test(3'd0, 32'hFFFF_FFFD, 32'd7, "mul", 1'b0);
    md_test(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh", 1'b0);
    md_test(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu", 1'b0);
    md_test(3'd4, 32'hFFFF_FFF9, 32'd2, "div", 1'b0);
    md_test(3'd6, 32'hFFFF_FFF9, 32'd2, "rem", 1'b0);
    md_test(3'd5, 32'd7, 32'd0, "divu0", 1'b0);
    md_test(3'd7, 32'd7, 32'd0, "remu0", 1'b0);
    md_test(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "divovf", 1'b0);
    md_test(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "removf", 1'b0);
    md_test(3'd0, 32'd1234, 32'hFFFF_FF00, "mul_stall", 1'b1);

    rdy_in = 1'b0;
    @(posedge clk_in); #1;
    check_eq("hold_valid", out_valid, 1);
    rdy_in = 1'b1;
    @(posedge clk_in); #1;
    check_eq("hold_release", out_valid, 0);

    for (int i = 0; i < 24; i++)
      md_test(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), "md_rnd", 1'b0);

    put_op(1'b1, 4'd4, 32'd1000, 32'd7);
    @(posedge clk_in); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk_in);
    #1;
    clear = 1'b1;
    @(posedge clk_in); #1;
    clear = 1'b0;
    check_eq("clr_ready", in_ready, 1);
    check_eq("clr_valid", out_valid, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_in); #1;
      if (out_valid) pulses++;
    end
    check_eq("clr_nopulse", pulses, 0);
    alu_test(4'd0, 32'd5, 32'd7, "clr_add");

    put_op(1'b0, 4'd0, 32'd1, 32'd1);
    clear = 1'b1;
    @(posedge clk_in); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    check_eq("clr_noaccept", out_valid, 0);

    put_op(1'b1, 4'd0, 32'd3, 32'd3);
    @(posedge clk_in); #1;
    in_valid = 1'b0;
    repeat (32) @(posedge clk_in);
    #1;
    clear = 1'b1;
    @(posedge clk_in); #1;
    clear = 1'b0;
    check_eq("clr_fix", out_valid, 0);
    check_eq("clr_fix_res", out_result, 12);

    put_op(1'b1, 4'd0, 32'd9, 32'd9);
    @(posedge clk_in); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk_in);
    #3;
    check_eq("run_busy", busy, 1);
    rst_in = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ready", in_ready, 1);
    check_eq("arst_result", out_result, 0);
    #2;
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
